// File: rtl/relogio_pkg.sv
// relogio_pkg -- shared definitions for the clock / stopwatch block.
// Holds the field widths of a time-of-day value, the per-field rollover
// limits, the packed time-of-day struct and a helper that detects the
// last centisecond before a full wrap.
package relogio_pkg;

    localparam int CS_W = 7;
    localparam int SS_W = 6;
    localparam int MM_W = 6;
    localparam int HH_W = 5;

    localparam int CS_MAX = 99;
    localparam int SS_MAX = 59;
    localparam int MM_MAX = 59;

    typedef struct packed {
        logic [HH_W-1:0] hh;
        logic [MM_W-1:0] mm;
        logic [SS_W-1:0] ss;
        logic [CS_W-1:0] cs;
    } tod_t;

    // True when t is hour_wrap-1:59:59.99, i.e. the next increment wraps to zero.
    function automatic logic tod_is_last(input tod_t t, input int hour_wrap);
        return (t.cs == CS_W'(CS_MAX)) && (t.ss == SS_W'(SS_MAX)) &&
               (t.mm == MM_W'(MM_MAX)) && (t.hh == HH_W'(hour_wrap - 1));
    endfunction

endpackage

// File: rtl/time_counter.sv
// time_counter -- hh:mm:ss.cs cascade counter.
// Ports:
//   clk, rst     rising-edge clock, synchronous active-high reset
//   i_en         advance by one centisecond this cycle
//   i_load       load i_load_val (highest priority after rst)
//   i_clr        zero the time (below load, above enable)
//   i_load_val   value loaded on i_load
//   o_time       current registered time
// All carries are resolved from the registered fields in the same cycle.
module time_counter
    import relogio_pkg::*;
#(
    parameter int HOUR_WRAP = 24
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_load,
    input  logic i_clr,
    input  tod_t i_load_val,
    output tod_t o_time
);

    tod_t r_time;
    logic w_cs_max;
    logic w_ss_max;
    logic w_mm_max;
    logic w_hh_max;

    assign w_cs_max = (r_time.cs == CS_W'(CS_MAX));
    assign w_ss_max = (r_time.ss == SS_W'(SS_MAX));
    assign w_mm_max = (r_time.mm == MM_W'(MM_MAX));
    assign w_hh_max = (r_time.hh == HH_W'(HOUR_WRAP - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_time <= '0;
        end else if (i_load) begin
            r_time <= i_load_val;
        end else if (i_clr) begin
            r_time <= '0;
        end else if (i_en) begin
            if (!w_cs_max) begin
                r_time.cs <= r_time.cs + CS_W'(1);
            end else begin
                r_time.cs <= '0;
                if (!w_ss_max) begin
                    r_time.ss <= r_time.ss + SS_W'(1);
                end else begin
                    r_time.ss <= '0;
                    if (!w_mm_max) begin
                        r_time.mm <= r_time.mm + MM_W'(1);
                    end else begin
                        r_time.mm <= '0;
                        r_time.hh <= w_hh_max ? '0 : r_time.hh + HH_W'(1);
                    end
                end
            end
        end
    end

    assign o_time = r_time;

endmodule

// File: rtl/relogio_cronometro.sv
// relogio_cronometro -- time-of-day clock plus stopwatch with lap freeze.
// Ports:
//   clk, rst                    rising-edge clock, synchronous active-high reset
//   mode                        0 = show clock, 1 = show stopwatch
//   start_stop / clear / lap    one-cycle stopwatch control pulses
//   set_en, set_hh/mm/ss        one-cycle clock load with its values
//   cs/ss/mm/hh                 displayed time (registered, binary)
//   running, lap_hold           stopwatch status flags
//   day_wrap                    pulse after the clock wraps to 00:00:00.00
//   set_err                     pulse after a rejected set_en
module relogio_cronometro
    import relogio_pkg::*;
#(
    parameter int DIV       = 500000,
    parameter int HOUR_WRAP = 24
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mode,
    input  logic            start_stop,
    input  logic            clear,
    input  logic            lap,
    input  logic            set_en,
    input  logic [HH_W-1:0] set_hh,
    input  logic [MM_W-1:0] set_mm,
    input  logic [SS_W-1:0] set_ss,
    output logic [CS_W-1:0] cs,
    output logic [SS_W-1:0] ss,
    output logic [MM_W-1:0] mm,
    output logic [HH_W-1:0] hh,
    output logic            running,
    output logic            lap_hold,
    output logic            day_wrap,
    output logic            set_err
);

    localparam int PW = $clog2(DIV);

    logic [PW-1:0] r_presc;
    logic          r_running;
    logic          r_lap_hold;
    logic          r_day_wrap;
    logic          r_set_err;
    tod_t          r_lap;
    tod_t          r_disp;

    logic w_tick;
    logic w_set_ok;
    logic w_load_clk;
    logic w_clk_en;
    logic w_sw_en;
    tod_t w_set_val;
    tod_t w_clk_time;
    tod_t w_sw_time;
    tod_t w_disp_next;

    assign w_tick     = (r_presc == PW'(DIV - 1));
    assign w_set_ok   = (int'(set_hh) < HOUR_WRAP) && (int'(set_mm) <= MM_MAX) &&
                        (int'(set_ss) <= SS_MAX);
    assign w_load_clk = set_en & w_set_ok;
    // Any set_en cycle (accepted or rejected) leaves the clock time untouched
    // by the tick, so a rejected load really leaves the time unchanged.
    assign w_clk_en   = w_tick & ~set_en;
    assign w_sw_en    = w_tick & r_running;

    always_comb begin
        w_set_val    = '0;
        w_set_val.hh = set_hh;
        w_set_val.mm = set_mm;
        w_set_val.ss = set_ss;
    end

    time_counter #(.HOUR_WRAP(HOUR_WRAP)) u_clock (
        .clk        (clk),
        .rst        (rst),
        .i_en       (w_clk_en),
        .i_load     (w_load_clk),
        .i_clr      (1'b0),
        .i_load_val (w_set_val),
        .o_time     (w_clk_time)
    );

    time_counter #(.HOUR_WRAP(HOUR_WRAP)) u_stopwatch (
        .clk        (clk),
        .rst        (rst),
        .i_en       (w_sw_en),
        .i_load     (1'b0),
        .i_clr      (clear),
        .i_load_val ('0),
        .o_time     (w_sw_time)
    );

    always_comb begin
        w_disp_next = w_clk_time;
        if (mode) begin
            w_disp_next = r_lap_hold ? r_lap : w_sw_time;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc    <= '0;
            r_running  <= 1'b0;
            r_lap_hold <= 1'b0;
            r_lap      <= '0;
            r_disp     <= '0;
            r_day_wrap <= 1'b0;
            r_set_err  <= 1'b0;
        end else begin
            // An accepted load restarts the centisecond period from zero.
            if (w_load_clk || w_tick) begin
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + PW'(1);
            end
            r_day_wrap <= w_clk_en & tod_is_last(w_clk_time, HOUR_WRAP);
            r_set_err  <= set_en & ~w_set_ok;
            r_disp     <= w_disp_next;
            if (clear) begin
                r_running  <= 1'b0;
                r_lap_hold <= 1'b0;
            end else begin
                if (start_stop) begin
                    r_running <= ~r_running;
                end
                if (lap) begin
                    if (r_lap_hold) begin
                        r_lap_hold <= 1'b0;
                    end else if (mode && r_running) begin
                        r_lap_hold <= 1'b1;
                        r_lap      <= w_sw_time;
                    end
                end
            end
        end
    end

    assign cs       = r_disp.cs;
    assign ss       = r_disp.ss;
    assign mm       = r_disp.mm;
    assign hh       = r_disp.hh;
    assign running  = r_running;
    assign lap_hold = r_lap_hold;
    assign day_wrap = r_day_wrap;
    assign set_err  = r_set_err;

endmodule

// File: tb/tb_relogio_cronometro.sv
// tb_relogio_cronometro -- directed vector table plus randomized run,
// every cycle checked against a reference model that keeps times as
// plain centisecond totals.
module tb_relogio_cronometro;

    localparam int DIV       = 2;
    localparam int HOUR_WRAP = 24;
    localparam int DAY_CS    = HOUR_WRAP * 360000;

    logic       clk = 1'b0;
    logic       rst, mode, start_stop, clear, lap, set_en;
    logic [4:0] set_hh;
    logic [5:0] set_mm, set_ss;
    logic [6:0] cs;
    logic [5:0] ss, mm;
    logic [4:0] hh;
    logic       running, lap_hold, day_wrap, set_err;

    always #5 clk = ~clk;

    relogio_cronometro #(.DIV(DIV), .HOUR_WRAP(HOUR_WRAP)) dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .start_stop (start_stop),
        .clear      (clear),
        .lap        (lap),
        .set_en     (set_en),
        .set_hh     (set_hh),
        .set_mm     (set_mm),
        .set_ss     (set_ss),
        .cs         (cs),
        .ss         (ss),
        .mm         (mm),
        .hh         (hh),
        .running    (running),
        .lap_hold   (lap_hold),
        .day_wrap   (day_wrap),
        .set_err    (set_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: times are centisecond totals within a day.
    int m_clk = 0, m_sw = 0, m_lap = 0, m_presc = 0, m_disp = 0;
    bit m_run = 0, m_hold = 0, m_dw = 0, m_err = 0;

    task automatic model_step();
        bit tick;
        int o_clk, o_sw;
        bit o_run, o_hold, valid;
        tick   = (m_presc == DIV - 1);
        o_clk  = m_clk;
        o_sw   = m_sw;
        o_run  = m_run;
        o_hold = m_hold;
        if (rst) begin
            m_clk = 0; m_sw = 0; m_lap = 0; m_presc = 0; m_disp = 0;
            m_run = 0; m_hold = 0; m_dw = 0; m_err = 0;
        end else begin
            m_disp = !mode ? o_clk : (o_hold ? m_lap : o_sw);
            m_dw   = 0;
            m_err  = 0;
            valid  = (int'(set_hh) < HOUR_WRAP) && (int'(set_mm) < 60) && (int'(set_ss) < 60);
            if (set_en && valid) begin
                m_clk   = int'(set_hh) * 360000 + int'(set_mm) * 6000 + int'(set_ss) * 100;
                m_presc = 0;
            end else begin
                m_presc = (m_presc + 1) % DIV;
                if (set_en) begin
                    m_err = 1;
                end else if (tick) begin
                    m_clk = o_clk + 1;
                    if (m_clk == DAY_CS) begin
                        m_clk = 0;
                        m_dw  = 1;
                    end
                end
            end
            if (clear) begin
                m_sw = 0; m_run = 0; m_hold = 0;
            end else begin
                if (tick && o_run) m_sw = (o_sw + 1) % DAY_CS;
                if (start_stop) m_run = !o_run;
                if (lap) begin
                    if (o_hold) begin
                        m_hold = 0;
                    end else if (mode && o_run) begin
                        m_lap  = o_sw;
                        m_hold = 1;
                    end
                end
            end
        end
    endtask

    function automatic logic [23:0] split_cs(input int t);
        return {5'(t / 360000), 6'((t / 6000) % 60), 6'((t / 100) % 60), 7'(t % 100)};
    endfunction

    function automatic int dut_total();
        return int'(hh) * 360000 + int'(mm) * 6000 + int'(ss) * 100 + int'(cs);
    endfunction

    // One clock edge: model follows the edge, outputs sampled 1 time unit later.
    task automatic do_cycle();
        logic [27:0] got, exp;
        @(posedge clk);
        model_step();
        #1;
        got = {hh, mm, ss, cs, running, lap_hold, day_wrap, set_err};
        exp = {split_cs(m_disp), m_run, m_hold, m_dw, m_err};
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL cycle_outputs t=%0t got=%h required=%h (hh mm ss cs run hold dw err)",
                     $time, got, exp);
        end
        rst = 0; start_stop = 0; clear = 0; lap = 0; set_en = 0;
    endtask

    typedef struct {
        logic rst_i, mode_i, ss_i, clr_i, lap_i, set_i;
        logic [4:0] shh;
        logic [5:0] smm, sss;
        int   cycles;
        int   exp_t;      // expected displayed time, centiseconds
        logic exp_run, exp_hold;
        int   exp_dw, exp_err;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic md, input logic sp, input logic cl,
                                input logic lp, input logic st, input int h, input int m,
                                input int s, input int cyc, input int et, input logic er,
                                input logic eh, input int edw, input int eer);
        vec_t v;
        v.rst_i = r; v.mode_i = md; v.ss_i = sp; v.clr_i = cl; v.lap_i = lp; v.set_i = st;
        v.shh = 5'(h); v.smm = 6'(m); v.sss = 6'(s);
        v.cycles = cyc; v.exp_t = et; v.exp_run = er; v.exp_hold = eh;
        v.exp_dw = edw; v.exp_err = eer;
        return v;
    endfunction

    vec_t vecs[16];

    initial begin
        int dw_cnt, err_cnt, tot;
        rst = 0; mode = 0; start_stop = 0; clear = 0; lap = 0; set_en = 0;
        set_hh = '0; set_mm = '0; set_ss = '0;

        //               rst md sp cl lp set hh  mm  ss  cyc  time run hold dw err
        vecs[0]  = mk(1, 0, 0, 0, 0, 0,  0,  0,  0,   1,    0, 0, 0, 0, 0); // reset
        vecs[1]  = mk(0, 0, 0, 0, 0, 0,  0,  0,  0, 201,  100, 0, 0, 0, 0); // 1.00 s
        vecs[2]  = mk(0, 0, 0, 0, 0, 1, 23, 59, 59, 202,    0, 0, 0, 1, 0); // day wrap
        vecs[3]  = mk(0, 0, 0, 0, 0, 1,  1, 60,  0,   3,    0, 0, 0, 0, 1); // bad set
        vecs[4]  = mk(0, 1, 1, 0, 0, 0,  0,  0,  0, 500,  249, 1, 0, 0, 0); // start
        vecs[5]  = mk(0, 1, 1, 0, 0, 0,  0,  0,  0,   2,  250, 0, 0, 0, 0); // stop
        vecs[6]  = mk(0, 1, 0, 0, 0, 0,  0,  0,  0, 100,  250, 0, 0, 0, 0); // static
        vecs[7]  = mk(0, 0, 0, 0, 0, 0,  0,  0,  0,   1,  302, 0, 0, 0, 0); // clock ran on
        vecs[8]  = mk(0, 1, 1, 0, 0, 0,  0,  0,  0,  20,  259, 1, 0, 0, 0); // restart
        vecs[9]  = mk(0, 1, 0, 0, 1, 0,  0,  0,  0,   1,  259, 1, 1, 0, 0); // lap capture
        vecs[10] = mk(0, 1, 0, 0, 0, 0,  0,  0,  0,  50,  259, 1, 1, 0, 0); // frozen
        vecs[11] = mk(0, 1, 0, 0, 1, 0,  0,  0,  0,   2,  285, 1, 0, 0, 0); // lap release
        vecs[12] = mk(0, 1, 1, 1, 0, 0,  0,  0,  0,   2,    0, 0, 0, 0, 0); // clear wins
        vecs[13] = mk(0, 1, 1, 0, 0, 0,  0,  0,  0,  10,    4, 1, 0, 0, 0); // run again
        vecs[14] = mk(1, 1, 0, 0, 0, 0,  0,  0,  0,   1,    0, 0, 0, 0, 0); // rst mid-count
        vecs[15] = mk(0, 1, 0, 0, 1, 0,  0,  0,  0,   2,    0, 0, 0, 0, 0); // lap ignored

        for (int i = 0; i < 16; i++) begin
            dw_cnt  = 0;
            err_cnt = 0;
            for (int c = 0; c < vecs[i].cycles; c++) begin
                mode = vecs[i].mode_i;
                if (c == 0) begin
                    rst = vecs[i].rst_i; start_stop = vecs[i].ss_i; clear = vecs[i].clr_i;
                    lap = vecs[i].lap_i; set_en = vecs[i].set_i;
                    set_hh = vecs[i].shh; set_mm = vecs[i].smm; set_ss = vecs[i].sss;
                end
                do_cycle();
                if (day_wrap) dw_cnt++;
                if (set_err) err_cnt++;
            end
            tot = dut_total();
            $display("vec %0d: time_cs=%0d running=%b lap_hold=%b day_wraps=%0d set_errs=%0d",
                     i, tot, running, lap_hold, dw_cnt, err_cnt);
            n_checks++;
            if (tot != vecs[i].exp_t || running !== vecs[i].exp_run || lap_hold !== vecs[i].exp_hold) begin
                n_errors++;
                $display("FAIL vec%0d_display got time=%0d run=%b hold=%b required time=%0d run=%b hold=%b",
                         i, tot, running, lap_hold, vecs[i].exp_t, vecs[i].exp_run, vecs[i].exp_hold);
            end
            n_checks++;
            if (dw_cnt != vecs[i].exp_dw || err_cnt != vecs[i].exp_err) begin
                n_errors++;
                $display("FAIL vec%0d_pulses got dw=%0d err=%0d required dw=%0d err=%0d",
                         i, dw_cnt, err_cnt, vecs[i].exp_dw, vecs[i].exp_err);
            end
        end

        // Randomized traffic, every cycle compared against the model.
        for (int n = 0; n < 3000; n++) begin
            rst        = ($urandom_range(0, 499) == 0);
            start_stop = ($urandom_range(0, 15) == 0);
            clear      = ($urandom_range(0, 63) == 0);
            lap        = ($urandom_range(0, 11) == 0);
            set_en     = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 1) == 0) begin
                set_hh = 5'd23; set_mm = 6'd59; set_ss = 6'd59;
            end else begin
                set_hh = 5'($urandom_range(0, 31));
                set_mm = 6'($urandom_range(0, 63));
                set_ss = 6'($urandom_range(0, 63));
            end
            if ($urandom_range(0, 39) == 0) mode = ~mode;
            do_cycle();
            if (n % 500 == 499)
                $display("random block %0d: time_cs=%0d running=%b lap_hold=%b", n / 500, dut_total(),
                         running, lap_hold);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/relogio_cronometro.md
RELOGIO_CRONOMETRO -- requirements
Module: relogio_cronometro

Interface
REQ-001 SHALL have parameter DIV, default 500000, meaning clk cycles per centisecond tick (DIV >= 2).
REQ-002 SHALL have parameter HOUR_WRAP, default 24, meaning the hour count at which hours wrap to 0 (12 or 24).
REQ-003 SHALL have port clk  in  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port mode  in  1  display select: 0 = clock, 1 = stopwatch.
REQ-006 SHALL have port start_stop  in  1  one-cycle pulse that toggles stopwatch running.
REQ-007 SHALL have port clear  in  1  one-cycle pulse that zeroes the stopwatch.
REQ-008 SHALL have port lap  in  1  one-cycle pulse that toggles the lap freeze.
REQ-009 SHALL have port set_en  in  1  one-cycle pulse that loads the clock time.
REQ-010 SHALL have ports set_hh/set_mm/set_ss  in  5/6/6  load values for the clock time.
REQ-011 SHALL have ports cs/ss/mm/hh  out  7/6/6/5  displayed centiseconds, seconds, minutes and hours (binary).
REQ-012 SHALL have port running  out  1  stopwatch running flag.
REQ-013 SHALL have port lap_hold  out  1  display frozen on a lap capture.
REQ-014 SHALL have port day_wrap  out  1  one-cycle pulse when clock hours wrap to 0.
REQ-015 SHALL have port set_err  out  1  one-cycle pulse when a set_en load is rejected.

Function
REQ-016 Prescaler SHALL count 0..DIV-1 continuously; tick SHALL be asserted for one cycle when the count equals DIV-1.
REQ-017 Clock time SHALL advance by 1 cs on every tick; cascade: cs 99->0 carries to ss, ss 59->0 carries to mm, mm 59->0 carries to hh, hh HOUR_WRAP-1->0.
REQ-018 All carries SHALL resolve in the same cycle as the tick, using registers only, with no combinational feedback loops.
REQ-019 day_wrap SHALL pulse in the cycle after clock time wraps from HOUR_WRAP-1:59:59.99 to 00:00:00.00.
REQ-020 On set_en with set_hh<HOUR_WRAP, set_mm<60 and set_ss<60, clock SHALL load hh:mm:ss with cs=0 and prescaler=0; set_en SHALL take priority over a coincident tick.
REQ-021 On set_en with any field out of range, clock time SHALL be unchanged and set_err SHALL pulse for one cycle.
REQ-022 Stopwatch time SHALL use the same cascade and share the prescaler tick, advancing only while running=1.
REQ-023 start_stop SHALL toggle running; clear SHALL zero stopwatch time and force running=0 and lap_hold=0.
REQ-024 When clear and start_stop coincide, clear SHALL win.
REQ-025 Stopwatch hours SHALL wrap at HOUR_WRAP without affecting day_wrap.
REQ-026 lap SHALL capture the stopwatch time and set lap_hold=1 only while mode=1 and running=1; lap while lap_hold=1 SHALL clear lap_hold; otherwise lap SHALL be ignored.
REQ-027 Outputs SHALL show the clock time when mode=0, the captured lap time when mode=1 and lap_hold=1, and live stopwatch time otherwise.
REQ-028 Outputs SHALL be registered with 1-cycle latency from internal state.
REQ-029 The clock SHALL keep running regardless of mode, running or lap_hold.

Reset
REQ-030 rst SHALL zero the prescaler, clock time, stopwatch time and lap capture, and set running, lap_hold, day_wrap and set_err to 0, effective in the cycle after assertion.
REQ-031 rst SHALL override every other input, including in the middle of operation.

Structure
REQ-032 Shared package relogio_pkg SHALL hold the field widths, the limits CS_MAX=99, SS_MAX=59 and MM_MAX=59, and a packed time-of-day struct typedef.
REQ-033 The cs/ss/mm/hh cascade with enable, load and clear SHALL be sub-module time_counter, instantiated twice (clock and stopwatch).

Verification (DIV=2)
REQ-034 Bench SHALL cover: rst, mode=0, 200 clk cycles -> 00:00:01.00.
REQ-035 Bench SHALL cover: set 23:59:59, 200 cycles -> 00:00:00.00 and exactly one day_wrap pulse.
REQ-036 Bench SHALL cover: set_en with set_mm=60 -> set_err pulse, time unchanged.
REQ-037 Bench SHALL cover: mode=1, start, 500 cycles, stop -> 00:00:02.50 held static while the clock keeps advancing.
REQ-038 Bench SHALL cover: lap while running -> outputs frozen while stopwatch continues internally; second lap -> live value shown.
REQ-039 Bench SHALL cover: clear with start_stop in the same cycle -> zero and running=0; rst mid-count -> all outputs zero next cycle.
